// File: rtl/nco_voice_bank_if.sv
// Bus bundle for nco_voice_bank: sweep trigger, per-voice config and the
// registered per-voice address stream.
interface nco_voice_bank_if #(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_VOICES = 4
);
  localparam int unsigned VOICE_BITS = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic                  sample_tick;
  logic                  cfg_we;
  logic [VOICE_BITS-1:0] cfg_voice;
  logic [ACC_WIDTH-1:0]  cfg_inc;
  logic                  cfg_sync;
  logic [ADDR_WIDTH-1:0] addr;
  logic [VOICE_BITS-1:0] voice_id;
  logic                  valid;
  logic                  wrap;
  logic                  busy;
  logic                  tick_overrun;

  // Controller side: issues ticks and config, consumes the address stream.
  modport master (
    output sample_tick, cfg_we, cfg_voice, cfg_inc, cfg_sync,
    input  addr, voice_id, valid, wrap, busy, tick_overrun
  );

  // NCO bank side.
  modport slave (
    input  sample_tick, cfg_we, cfg_voice, cfg_inc, cfg_sync,
    output addr, voice_id, valid, wrap, busy, tick_overrun
  );
endinterface

// File: rtl/nco_voice_bank.sv
// Time-multiplexed NCO bank: one phase accumulator and one increment per
// voice, swept one voice per clock on each sample tick.
module nco_voice_bank #(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_VOICES = 4
) (
  input logic             clk,
  input logic             reset,
  nco_voice_bank_if.slave bus
);
  localparam int unsigned VOICE_BITS = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [VOICE_BITS:0]   NumVoices = (VOICE_BITS + 1)'(NUM_VOICES);
  localparam logic [VOICE_BITS-1:0] LastIdx   = VOICE_BITS'(NUM_VOICES - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q;
  logic [VOICE_BITS-1:0] idx_q;
  logic [ACC_WIDTH-1:0]  phase_q [NUM_VOICES];
  logic [ACC_WIDTH-1:0]  inc_q   [NUM_VOICES];

  logic                  valid_q;
  logic                  busy_q;
  logic                  wrap_q;
  logic                  overrun_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [VOICE_BITS-1:0] voice_id_q;

  logic                  start;
  logic                  proc_en;
  logic                  busy_now;
  logic [VOICE_BITS-1:0] proc_idx;
  logic [ACC_WIDTH:0]    sum;
  logic                  cfg_ok;
  logic                  sync_hit;

  // Decode which voice is processed at this edge and its accumulator sum.
  always_comb begin
    busy_now = (state_q == StRun) || valid_q;
    // The last valid cycle is still busy, so a tick there is dropped.
    start    = bus.sample_tick && (state_q == StIdle) && !valid_q;
    proc_en  = start || (state_q == StRun);
    proc_idx = (state_q == StRun) ? idx_q : '0;
    sum      = {1'b0, phase_q[proc_idx]} + {1'b0, inc_q[proc_idx]};
    cfg_ok   = bus.cfg_we && ({1'b0, bus.cfg_voice} < NumVoices);
    sync_hit = cfg_ok && bus.cfg_sync && proc_en && (bus.cfg_voice == proc_idx);
  end

  // Sweep FSM, per-voice storage and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      wrap_q     <= 1'b0;
      overrun_q  <= 1'b0;
      addr_q     <= '0;
      voice_id_q <= '0;
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        phase_q[v] <= '0;
        inc_q[v]   <= '0;
      end
    end else begin
      valid_q   <= proc_en;
      // busy mirrors the valid window exactly: RUN is always inside it.
      busy_q    <= proc_en;
      overrun_q <= bus.sample_tick && busy_now;
      wrap_q    <= proc_en && sum[ACC_WIDTH] && !sync_hit;
      if (proc_en) begin
        voice_id_q <= proc_idx;
        addr_q     <= sync_hit ? '0 : sum[ACC_WIDTH-1 -: ADDR_WIDTH];
      end

      unique case (state_q)
        StIdle: begin
          if (start && (NUM_VOICES > 1)) begin
            state_q <= StRun;
            idx_q   <= VOICE_BITS'(1);
          end
        end
        StRun: begin
          if (idx_q == LastIdx) begin
            state_q <= StIdle;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          idx_q   <= '0;
        end
      endcase

      // Accumulator update first; a same-edge sync overrides it. The update
      // reads inc_q, so a colliding increment write lands next sweep.
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        if (proc_en && (proc_idx == VOICE_BITS'(v))) begin
          phase_q[v] <= sum[ACC_WIDTH-1:0];
        end
        if (cfg_ok && (bus.cfg_voice == VOICE_BITS'(v))) begin
          inc_q[v] <= bus.cfg_inc;
          if (bus.cfg_sync) begin
            phase_q[v] <= '0;
          end
        end
      end
    end
  end

  assign bus.addr         = addr_q;
  assign bus.voice_id     = voice_id_q;
  assign bus.valid        = valid_q;
  assign bus.wrap         = wrap_q;
  assign bus.busy         = busy_q;
  assign bus.tick_overrun = overrun_q;
endmodule
